mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Bus-side sequencer directly downstream of the memory stage; sole owner of the data-bus (dbus) handshake for loads/stores.
- Captures one request from the memory stage, holds dbus request fields stable until accepted, waits for data, then presents size-aligned, extended load data to writeback.
- Drives a stall to the pipeline for the whole transaction.

Parameters:
ADDR_W, 64, width of request/bus address
DATA_W, 64, bus data width; fixed at 64 (8 byte lanes), other values unsupported

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  memory stage has a load or store this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_size  input  3  0=1B, 1=2B, 2=4B, 3=8B (MSIZE1..MSIZE8); other codes undefined
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_wdata  input  64  store data, right-aligned
flush  input  1  squash the in-flight instruction's result
dreq_valid  output  1  dbus request valid
dreq_addr  output  ADDR_W  dbus address (registered copy of req_addr)
dreq_size  output  3  dbus size
dreq_strobe  output  8  byte-lane write enables; 0 for loads
dreq_data  output  64  lane-aligned store data
dresp_addr_ok  input  1  bus accepted address this cycle
dresp_data_ok  input  1  bus data/ack valid this cycle
dresp_data  input  64  raw 64-bit read word
stall  output  1  hold memory stage and everything upstream
done  output  1  one-cycle pulse: transaction complete, result valid
rdata  output  64  extracted, extended load data (valid with done, load only)
misaligned  output  1  valid with done; address not size-aligned

Behaviour:
- Reset: state IDLE; dreq_valid=0, dreq_strobe=0, dreq_addr/size/data=0, done=0, rdata=0, misaligned=0, flush_pending=0. Reset wins over every other event, including mid-transaction; dreq_valid drops the cycle after reset asserts.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if req_valid, register addr/size/write/unsigned/wdata, compute strobe and lane data, go REQ. stall = req_valid (combinational, same cycle).
- REQ: dreq_valid=1, all dreq fields constant. addr_ok&data_ok -> DONE; addr_ok only -> WAIT; else stay. stall=1.
- WAIT: dreq_valid=0. data_ok -> DONE (latch dresp_data); else stay. stall=1.
- DONE: done=1 (unless flush_pending), stall=0, rdata and misaligned valid; next state IDLE unconditionally. No capture in DONE, so the same request is never issued twice. Minimum transaction: 3 cycles (IDLE capture, REQ with addr_ok&data_ok, DONE).
- Strobe: base mask 0x01/0x03/0x0F/0xFF for size 0..3, shifted left by addr[2:0], truncated to 8 bits. dreq_data = req_wdata << (8*addr[2:0]). Loads: strobe 0, dreq_data 0.
- Load extract: word = dresp_data >> (8*addr[2:0]); keep low 8/16/32/64 bits; extend per req_unsigned. Stores: rdata=0.
- Flush: a bus transaction in REQ/WAIT is never cancelled (valid must stay up until addr_ok). flush in REQ or WAIT sets flush_pending; the transaction completes, DONE suppresses done; flush_pending clears on leaving DONE. Flush in IDLE blocks capture that cycle.
- Back-to-back: the new request is captured in the IDLE cycle after DONE.

Optional Feature:
- MISALIGN_CHECK_EN defined: in IDLE, if addr is not a multiple of 2^size, skip the bus (dreq_valid never asserts) and go straight to DONE with misaligned=1, rdata=0, done=1 (2-cycle path).
- Not defined: misaligned is tied 0; every request is issued to the bus, strobe computed as above (overflowing lanes truncated).

Test Plan:
- Load 8B at 0x80000008, bus gives addr_ok&data_ok first REQ cycle, data 0x1122334455667788 -> stall high 2 cycles, done in cycle 3, rdata=0x1122334455667788.
- Signed byte load at addr 0x...03, dresp_data=0x00000000_80000000 -> strobe 0, rdata=0xFFFFFFFFFFFFFF80; same with req_unsigned=1 -> 0x80.
- Store 2B wdata=0xBEEF at addr 0x...06, addr_ok delayed 3 cycles then data_ok 2 cycles later -> dreq fields constant throughout REQ, strobe=0xC0, dreq_data=0xBEEF000000000000, dreq_valid low in WAIT, done once.
- Flush asserted during WAIT of a load -> bus transaction finishes, done stays 0, next request captured normally.
- Reset asserted during REQ -> next cycle dreq_valid=0, stall=0, state IDLE, no done.
- MISALIGN_CHECK_EN: 4B load at 0x...02 -> no dreq_valid, done=1 and misaligned=1 on cycle 2; without macro -> bus request issued, misaligned=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-bus sequencer for loads/stores: captures one memory-stage request, drives the dbus handshake,
// and returns lane-extracted, extended load data. Optional MISALIGN_CHECK_EN short-circuits unaligned requests.
module mem_access_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fpend_q, fpend_d;
    logic [7:0]        base_mask;
    logic [DATA_W-1:0] load_word;

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw, input logic [2:0] off,
                                                  input logic [1:0] sz, input logic uns);
        logic [DATA_W-1:0] w;
        w = raw >> {off, 3'b000};
        case (sz)
            2'd0:    extract = uns ? {56'd0, w[7:0]}  : {{56{w[7]}}, w[7:0]};
            2'd1:    extract = uns ? {48'd0, w[15:0]} : {{48{w[15]}}, w[15:0]};
            2'd2:    extract = uns ? {32'd0, w[31:0]} : {{32{w[31]}}, w[31:0]};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        case (req_size[1:0])
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Stores report no read data.
    assign load_word = write_q ? '0 : extract(dresp_data, addr_q[2:0], size_q[1:0], uns_q);

`ifdef MISALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic unaligned;
    logic [2:0] align_mask;
    always_comb begin
        case (req_size[1:0])
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end
    assign unaligned  = (req_addr[2:0] & align_mask) != 3'b000;
    assign misaligned = (state_q == S_DONE) && mis_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        uns_d    = uns_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fpend_d  = fpend_q;
        stall    = 1'b0;
`ifdef MISALIGN_CHECK_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid && !flush) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    write_d  = req_write;
                    uns_d    = req_unsigned;
                    strobe_d = req_write ? (base_mask << req_addr[2:0]) : 8'h00;
                    wdata_d  = req_write ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
                    rdata_d  = '0;
                    fpend_d  = 1'b0;
                    state_d  = S_REQ;
`ifdef MISALIGN_CHECK_EN
                    mis_d = unaligned;
                    if (unaligned) state_d = S_DONE;
`endif
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (flush) fpend_d = 1'b1;
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        rdata_d = load_word;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (flush) fpend_d = 1'b1;
                if (dresp_data_ok) begin
                    rdata_d = load_word;
                    state_d = S_DONE;
                end
            end
            default: begin
                fpend_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            uns_q    <= 1'b0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fpend_q  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            uns_q    <= uns_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fpend_q  <= fpend_d;
`ifdef MISALIGN_CHECK_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign dreq_valid  = (state_q == S_REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = wdata_q;
    assign done        = (state_q == S_DONE) && !fpend_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned, flush;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        stall, done, misaligned;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_size = 0; req_unsigned = 0;
        req_wdata = '0; flush = 0; dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
    endtask

    task automatic put_req(input logic wr, input logic [63:0] a, input logic [2:0] sz,
                           input logic uns, input logic [63:0] wd);
        req_valid = 1; req_write = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick(); sample();
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b want 0", dreq_valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if ({rdata, dreq_addr, dreq_data} !== '0) begin n_fail++; $display("FAIL reset_regs: rdata %h addr %h data %h want 0", rdata, dreq_addr, dreq_data); end
        n_checks++; if ({dreq_strobe, dreq_size, misaligned} !== '0) begin n_fail++; $display("FAIL reset_ctl: strobe %h size %0d mis %b want 0", dreq_strobe, dreq_size, misaligned); end
        tick(); reset = 0;
    endtask

    task automatic test_load8();
        tick(); put_req(0, 64'h8000_0008, 3'd3, 0, '0); sample();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load8_stall_c1: got %b want 1", stall); end
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL load8_valid_c1: got %b want 0", dreq_valid); end
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h1122334455667788; sample();
        n_checks++; if ({dreq_valid, stall} !== 2'b11) begin n_fail++; $display("FAIL load8_req: valid/stall got %b want 11", {dreq_valid, stall}); end
        n_checks++; if (dreq_addr !== 64'h8000_0008 || dreq_size !== 3'd3 || dreq_strobe !== 8'h00) begin n_fail++; $display("FAIL load8_fields: addr %h size %0d strobe %h want 80000008/3/00", dreq_addr, dreq_size, dreq_strobe); end
        tick(); idle_inputs(); sample();
        n_checks++; if ({done, stall} !== 2'b10) begin n_fail++; $display("FAIL load8_done: done/stall got %b want 10", {done, stall}); end
        n_checks++; if (rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL load8_rdata: got %h want 1122334455667788", rdata); end
        tick(); sample();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load8_pulse: done got %b want 0", done); end
    endtask

    task automatic test_byte_load(input logic uns, input logic [63:0] exp);
        tick(); put_req(0, 64'h0000_1003, 3'd0, uns, 64'hFFFF_FFFF_FFFF_FFFF); sample();
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h0000_0000_8000_0000; sample();
        n_checks++; if (dreq_strobe !== 8'h00 || dreq_data !== 64'h0) begin n_fail++; $display("FAIL byte_load_strobe u=%b: strobe %h data %h want 00/0", uns, dreq_strobe, dreq_data); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b1 || rdata !== exp) begin n_fail++; $display("FAIL byte_load_rdata u=%b: done %b rdata %h want 1/%h", uns, done, rdata, exp); end
        tick();
    endtask

    task automatic test_store_delay();
        int done_cnt = 0;
        tick(); put_req(1, 64'h0000_2006, 3'd1, 0, 64'h0000_0000_0000_BEEF); sample();
        for (int i = 0; i < 4; i++) begin
            tick(); idle_inputs(); dresp_addr_ok = (i == 3); sample();
            n_checks++; if (dreq_valid !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL store_req%0d_valid: valid %b stall %b want 1/1", i, dreq_valid, stall); end
            n_checks++; if (dreq_strobe !== 8'hC0 || dreq_data !== 64'hBEEF_0000_0000_0000 || dreq_addr !== 64'h2006 || dreq_size !== 3'd1)
                begin n_fail++; $display("FAIL store_req%0d_fields: strobe %h data %h addr %h size %0d", i, dreq_strobe, dreq_data, dreq_addr, dreq_size); end
        end
        for (int i = 0; i < 2; i++) begin
            tick(); idle_inputs(); dresp_data_ok = (i == 1); sample();
            n_checks++; if (dreq_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL store_wait%0d: valid %b stall %b want 0/1", i, dreq_valid, stall); end
            if (done === 1'b1) done_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            tick(); idle_inputs(); sample();
            if (done === 1'b1) done_cnt++;
            if (i == 0) begin
                n_checks++; if (done !== 1'b1 || rdata !== 64'h0) begin n_fail++; $display("FAIL store_done: done %b rdata %h want 1/0", done, rdata); end
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL store_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_flush();
        tick(); put_req(0, 64'h3000, 3'd2, 1, '0); flush = 1; sample();
        tick(); idle_inputs(); sample();
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block: dreq_valid got %b want 0", dreq_valid); end
        tick(); put_req(0, 64'h3004, 3'd2, 1, '0); sample();
        tick(); idle_inputs(); dresp_addr_ok = 1; sample();
        tick(); idle_inputs(); flush = 1; sample();
        n_checks++; if (dreq_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL flush_wait: valid %b stall %b want 0/1", dreq_valid, stall); end
        tick(); idle_inputs(); dresp_data_ok = 1; dresp_data = 64'h1234_5678_9ABC_DEF0; sample();
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: done %b stall %b want 0/0", done, stall); end
        tick(); put_req(0, 64'h3008, 3'd3, 1, '0); sample();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_next_stall: got %b want 1", stall); end
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'hCAFE_F00D_0000_0001; sample();
        n_checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h3008) begin n_fail++; $display("FAIL flush_next_req: valid %b addr %h want 1/3008", dreq_valid, dreq_addr); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b1 || rdata !== 64'hCAFE_F00D_0000_0001) begin n_fail++; $display("FAIL flush_next_done: done %b rdata %h want 1/cafef00d00000001", done, rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        tick(); put_req(0, 64'h6000, 3'd3, 0, '0); sample();
        tick(); idle_inputs(); sample();
        n_checks++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_req: dreq_valid got %b want 1", dreq_valid); end
        reset = 1;
        tick(); reset = 0; dresp_addr_ok = 1; dresp_data_ok = 1; sample();
        n_checks++; if ({dreq_valid, stall, done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_after: valid/stall/done got %b want 000", {dreq_valid, stall, done}); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b0 || dreq_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: done %b valid %b want 0/0", done, dreq_valid); end
    endtask

    task automatic test_back_to_back();
        tick(); put_req(0, 64'h7000, 3'd3, 0, '0); sample();
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'hA5A5; sample();
        tick(); idle_inputs(); put_req(0, 64'h7010, 3'd3, 0, '0); sample();
        n_checks++; if (done !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_a: done %b stall %b want 1/0", done, stall); end
        tick(); sample();
        n_checks++; if (dreq_valid !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: valid %b stall %b done %b want 0/1/0", dreq_valid, stall, done); end
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h5A5A; sample();
        n_checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h7010) begin n_fail++; $display("FAIL b2b_req_b: valid %b addr %h want 1/7010", dreq_valid, dreq_addr); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b1 || rdata !== 64'h5A5A) begin n_fail++; $display("FAIL b2b_done_b: done %b rdata %h want 1/5a5a", done, rdata); end
        tick();
    endtask

    task automatic test_misalign();
        tick(); put_req(0, 64'h4002, 3'd2, 1, '0); sample();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mis_stall: got %b want 1", stall); end
        tick(); idle_inputs(); dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h0123_4567_89AB_CDEF; sample();
`ifdef MISALIGN_CHECK_EN
        n_checks++; if ({dreq_valid, done, misaligned} !== 3'b011 || rdata !== 64'h0) begin n_fail++; $display("FAIL mis_short: valid/done/mis %b rdata %h want 011/0", {dreq_valid, done, misaligned}, rdata); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b0 || dreq_valid !== 1'b0) begin n_fail++; $display("FAIL mis_after: done %b valid %b want 0/0", done, dreq_valid); end
`else
        n_checks++; if (dreq_valid !== 1'b1 || misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_issue: valid %b mis %b want 1/0", dreq_valid, misaligned); end
        tick(); idle_inputs(); sample();
        n_checks++; if (done !== 1'b1 || misaligned !== 1'b0 || rdata !== 64'h0000_0000_4567_89AB) begin n_fail++; $display("FAIL mis_done: done %b mis %b rdata %h want 1/0/456789ab", done, misaligned, rdata); end
        tick(); put_req(1, 64'h5004, 3'd3, 0, 64'h1122334455667788); sample();
        tick(); idle_inputs(); sample();
        n_checks++; if (dreq_strobe !== 8'hF0 || dreq_data !== 64'h5566_7788_0000_0000) begin n_fail++; $display("FAIL strobe_trunc: strobe %h data %h want f0/5566778800000000", dreq_strobe, dreq_data); end
        dresp_addr_ok = 1; dresp_data_ok = 1;
        tick(); idle_inputs(); sample();
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load8();
        test_byte_load(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        test_byte_load(1'b1, 64'h0000_0000_0000_0080);
        test_store_delay();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
